axil_wr_router: RTL and testbench

AXIL_WR_ROUTER -- requirements
Module: axil_wr_router

---
 rtl/axil_pkg.sv | 17 +
 rtl/axil_addr_decode.sv | 32 +++
 rtl/axil_wr_router.sv | 171 +++++++++++++++++
 tb/tb_axil_wr_router.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite response codes and write-router FSM states.
// Imported by axil_wr_router and axil_addr_decode.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_B,
    DECERR,
    RESP
  } state_t;

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decoder: upper address bits pick a slave window.
// Emits a one-hot select and a hit flag (no hit means decode error).
module axil_addr_decode
  import axil_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SPAN_LOG2  = 12
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  localparam int IDX_W = ADDR_W - SPAN_LOG2;

  logic [IDX_W-1:0] idx;
  logic             unused_lo;

  assign idx       = addr[ADDR_W-1:SPAN_LOG2];
  assign unused_lo = ^addr[SPAN_LOG2-1:0];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/axil_wr_router.sv
// AXI-Lite write router: one master, NUM_SLAVES windows, one write in flight.
// Optional watchdog: define AXIL_WR_ROUTER_TIMEOUT_EN.
module axil_wr_router
  import axil_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SPAN_LOG2  = 12
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_W-1:0]       s_wdata,
  input  logic [DATA_W/8-1:0]     s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic [NUM_SLAVES-1:0]   m_awvalid,
  input  logic [NUM_SLAVES-1:0]   m_awready,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  output logic [NUM_SLAVES-1:0]   m_wvalid,
  input  logic [NUM_SLAVES-1:0]   m_wready,
  input  logic [2*NUM_SLAVES-1:0] m_bresp,
  input  logic [NUM_SLAVES-1:0]   m_bvalid,
  output logic [NUM_SLAVES-1:0]   m_bready
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic                  aw_done, w_done;
  logic                  aw_hs, w_hs, b_hit;
  logic [1:0]            bresp_q, slv_bresp;
  logic                  tmo;

  axil_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SPAN_LOG2  (SPAN_LOG2)
  ) u_dec (
    .addr (s_awaddr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

`ifdef AXIL_WR_ROUTER_TIMEOUT_EN
  logic [15:0] cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET)
      cnt <= '0;
    else if (state == ISSUE || state == WAIT_B)
      cnt <= cnt + 16'd1;
    else
      cnt <= '0;
  end

  assign tmo = (cnt == 16'hFFFF);
`else
  assign tmo = 1'b0;
`endif

  // Only the selected slave's handshakes count; others are ignored.
  assign aw_hs = (state == ISSUE) && !aw_done && |(m_awready & sel_q);
  assign w_hs  = (state == ISSUE) && !w_done && |(m_wready & sel_q);
  assign b_hit = |(m_bvalid & sel_q);

  always_comb begin
    slv_bresp = RESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) slv_bresp = m_bresp[2*i +: 2];
    end
  end

  always_comb begin
    state_nxt = state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    unique case (state)
      IDLE: begin
        s_awready = 1'b1;
        s_wready  = 1'b1;
        if (s_awvalid && s_wvalid)
          state_nxt = dec_hit ? ISSUE : DECERR;
      end
      ISSUE: begin
        m_awvalid = (aw_done || tmo) ? '0 : sel_q;
        m_wvalid  = (w_done || tmo) ? '0 : sel_q;
        if (tmo)
          state_nxt = RESP;
        else if ((aw_done || aw_hs) && (w_done || w_hs))
          state_nxt = WAIT_B;
      end
      WAIT_B: begin
        m_bready = tmo ? '0 : sel_q;
        if (tmo || b_hit) state_nxt = RESP;
      end
      DECERR: state_nxt = RESP;
      RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = bresp_q;
        if (s_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences every output in the same cycle it is raised.
    if (ARESET) begin
      state_nxt = IDLE;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_bresp   = 2'b00;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      sel_q   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bresp_q <= RESP_OKAY;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && s_awvalid && s_wvalid) begin
        addr_q  <= s_awaddr;
        data_q  <= s_wdata;
        strb_q  <= s_wstrb;
        sel_q   <= dec_sel;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (state == DECERR)
        bresp_q <= RESP_DECERR;
      else if ((state == ISSUE || state == WAIT_B) && tmo)
        bresp_q <= RESP_SLVERR;
      else if (state == WAIT_B && b_hit)
        bresp_q <= slv_bresp;
    end
  end

  assign m_awaddr = addr_q;
  assign m_wdata  = data_q;
  assign m_wstrb  = strb_q;

endmodule

// File: tb/tb_axil_wr_router.sv
// Scoreboard bench for axil_wr_router (4 slaves, 4 KiB windows).
// Covers routing, decode error, split handshakes, B stall, reset, timeout.
module tb_axil_wr_router;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awvalid;
  logic [3:0]  m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [3:0]  m_wvalid;
  logic [3:0]  m_wready;
  logic [7:0]  m_bresp;
  logic [3:0]  m_bvalid;
  logic [3:0]  m_bready;

  int checks = 0;
  int errors = 0;
  int b_seen = 0;
  int b_exp  = 0;

  int          exp_aw_idx[$];
  logic [31:0] exp_aw_addr[$];
  int          exp_w_idx[$];
  logic [31:0] exp_w_data[$];
  logic [3:0]  exp_w_strb[$];
  logic [1:0]  exp_b[$];

  logic [1:0] bcfg [4];
  logic [3:0] silent;
  logic [3:0] got_aw, got_w;

  always #5 ACLK = ~ACLK;

  axil_wr_router #(
    .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SPAN_LOG2(12)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", n);
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Slave models: raise bvalid once both AW and W have landed.
  initial begin
    logic [3:0] aw_hs, w_hs, b_hs;
    logic       rst;
    got_aw   = '0;
    got_w    = '0;
    m_bvalid = '0;
    m_bresp  = '0;
    forever begin
      @(negedge ACLK);
      aw_hs = m_awvalid & m_awready;
      w_hs  = m_wvalid & m_wready;
      b_hs  = m_bvalid & m_bready;
      rst   = ARESET;
      @(posedge ACLK);
      #1;
      if (rst) begin
        got_aw   = '0;
        got_w    = '0;
        m_bvalid = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (b_hs[i]) m_bvalid[i] = 1'b0;
          if (aw_hs[i]) got_aw[i] = 1'b1;
          if (w_hs[i]) got_w[i] = 1'b1;
          if (got_aw[i] && got_w[i] && !silent[i] && !m_bvalid[i]) begin
            m_bvalid[i]      = 1'b1;
            m_bresp[2*i +: 2] = bcfg[i];
            got_aw[i]        = 1'b0;
            got_w[i]         = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever a handshake is visible.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        chk("onehot",
            {63'd0, $onehot0(m_awvalid) && $onehot0(m_wvalid)
                    && $onehot0(m_bready)}, 64'd1);
        if (|(m_awvalid & m_awready)) begin
          if (exp_aw_idx.size() == 0) flag("aw_unexpected");
          else begin
            chk("aw_idx", 64'(oh2i(m_awvalid)), 64'(exp_aw_idx.pop_front()));
            chk("aw_addr", 64'(m_awaddr), 64'(exp_aw_addr.pop_front()));
          end
        end
        if (|(m_wvalid & m_wready)) begin
          if (exp_w_idx.size() == 0) flag("w_unexpected");
          else begin
            chk("w_idx", 64'(oh2i(m_wvalid)), 64'(exp_w_idx.pop_front()));
            chk("w_data", 64'(m_wdata), 64'(exp_w_data.pop_front()));
            chk("w_strb", 64'(m_wstrb), 64'(exp_w_strb.pop_front()));
          end
        end
        if (s_bvalid && s_bready) begin
          b_seen++;
          if (exp_b.size() == 0) flag("b_unexpected");
          else chk("b_resp", 64'(s_bresp), 64'(exp_b.pop_front()));
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input bit want_b,
                    input logic [1:0] br);
    int n = 0;
    int idx;
    idx = int'(a[31:12]);
    if (idx < 4) begin
      exp_aw_idx.push_back(idx);
      exp_aw_addr.push_back(a);
      exp_w_idx.push_back(idx);
      exp_w_data.push_back(d);
      exp_w_strb.push_back(s);
    end
    if (want_b) begin
      exp_b.push_back(br);
      b_exp++;
    end
    @(posedge ACLK);
    #1;
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    @(negedge ACLK);
    while (!s_awready && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_awready) flag("accept_timeout");
    @(posedge ACLK);
    #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_b.size() != 0 && n < lim) begin
      @(negedge ACLK);
      n++;
    end
    if (exp_b.size() != 0) begin
      flag("drain_timeout");
      exp_b.delete();
    end
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int n;
    ARESET    = 1'b1;
    s_awaddr  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_bready  = 1'b1;
    m_awready = 4'hF;
    m_wready  = 4'hF;
    silent    = '0;
    for (int i = 0; i < 4; i++) bcfg[i] = 2'b00;

    repeat (3) @(negedge ACLK);
    chk("rst_awready", 64'(s_awready), 64'd0);
    chk("rst_wready", 64'(s_wready), 64'd0);
    chk("rst_outs", 64'({m_awvalid, m_wvalid, m_bready, s_bvalid, s_bresp}),
        64'd0);
    @(posedge ACLK);
    #1;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    ARESET    = 1'b0;
    @(negedge ACLK);
    chk("idle_awready", 64'(s_awready), 64'd1);
    chk("idle_wready", 64'(s_wready), 64'd1);

    // Routed write to slave 2 at minimum latency.
    wr(32'h2004, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
    @(negedge ACLK);
    chk("aw_sel", 64'(m_awvalid), 64'h4);
    chk("w_sel", 64'(m_wvalid), 64'h4);
    @(negedge ACLK);
    chk("b_early", 64'(s_bvalid), 64'd0);
    chk("bready_sel", 64'(m_bready), 64'h4);
    @(negedge ACLK);
    chk("b_latency", 64'(s_bvalid), 64'd1);
    drain(50);

    // Index 5: decode error, no slave touched.
    wr(32'h5000, 32'h11111111, 4'hF, 1'b1, 2'b11);
    @(negedge ACLK);
    chk("dec_aw", 64'(m_awvalid), 64'd0);
    chk("dec_w", 64'(m_wvalid), 64'd0);
    @(negedge ACLK);
    chk("dec_bvalid", 64'(s_bvalid), 64'd1);
    chk("dec_bresp", 64'(s_bresp), 64'h3);
    chk("resp_awready", 64'(s_awready), 64'd0);
    drain(50);

    // Window boundaries and back-to-back traffic.
    bcfg[3] = 2'b10;
    wr(32'h4000, 32'h22222222, 4'hF, 1'b1, 2'b11);
    wr(32'hFFFF_F000, 32'h33333333, 4'hF, 1'b1, 2'b11);
    wr(32'h3FFC, 32'h12345678, 4'b0101, 1'b1, 2'b10);
    wr(32'h0FFC, 32'hCAFEF00D, 4'b1000, 1'b1, 2'b00);
    drain(100);

    // W ready leads AW ready by 3 cycles on slave 1.
    m_awready = 4'hD;
    m_wready  = 4'hD;
    wr(32'h1000, 32'hA5A5A5A5, 4'hF, 1'b1, 2'b00);
    m_wready[1] = 1'b1;
    @(posedge ACLK);
    #1;
    m_wready[1] = 1'b0;
    @(negedge ACLK);
    chk("split_wdrop", 64'(m_wvalid), 64'd0);
    chk("split_awhold", 64'(m_awvalid), 64'h2);
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #1;
    m_awready[1] = 1'b1;
    @(posedge ACLK);
    #1;
    m_awready[1] = 1'b0;
    @(negedge ACLK);
    chk("split_awdrop", 64'(m_awvalid), 64'd0);
    m_awready = 4'hF;
    m_wready  = 4'hF;
    drain(50);

    // Master stalls B for 5 cycles.
    bcfg[0]  = 2'b01;
    s_bready = 1'b0;
    wr(32'h0010, 32'h0BADCAFE, 4'hF, 1'b1, 2'b01);
    n = 0;
    while (!s_bvalid && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_bvalid", 64'(s_bvalid), 64'd1);
      chk("stall_bresp", 64'(s_bresp), 64'h1);
      chk("stall_awready", 64'(s_awready), 64'd0);
      @(negedge ACLK);
    end
    @(posedge ACLK);
    #1;
    s_bready = 1'b1;
    drain(50);

    // Reset while waiting on a silent slave abandons the write.
    silent[2] = 1'b1;
    wr(32'h2008, 32'hAAAA5555, 4'hF, 1'b0, 2'b00);
    n = 0;
    while (!m_bready[2] && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("waitb_bready", 64'(m_bready), 64'h4);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_outs",
        64'({m_awvalid, m_wvalid, m_bready, s_bvalid, s_bresp,
             s_awready, s_wready}), 64'd0);
    @(posedge ACLK);
    #1;
    ARESET    = 1'b0;
    silent[2] = 1'b0;
    @(negedge ACLK);
    chk("postrst_bvalid", 64'(s_bvalid), 64'd0);
    chk("postrst_awready", 64'(s_awready), 64'd1);

    bcfg[3] = 2'b00;
    wr(32'h3010, 32'h5A5A0000, 4'b0011, 1'b1, 2'b00);
    drain(50);

`ifdef AXIL_WR_ROUTER_TIMEOUT_EN
    silent[3] = 1'b1;
    wr(32'h3000, 32'h77777777, 4'hF, 1'b1, 2'b10);
    drain(70000);
`endif

    repeat (3) @(negedge ACLK);
    chk("b_count", 64'(b_seen), 64'(b_exp));
    chk("aw_left", 64'(exp_aw_idx.size()), 64'd0);
    chk("w_left", 64'(exp_w_idx.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
